// File: rtl/main_fifo_ctrl.sv
// Transaction-layer entry FIFO: buffers source words, raises Main_pause near full,
// flags overflow sticky until init, and is drained by the VC stage via pop/valid.
module main_fifo_ctrl #(
  parameter int unsigned BITNUMBER = 8,
  parameter int unsigned LENGTH    = 8,
  parameter int unsigned ADDR      = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic [LENGTH-1:0]    Umbral_MF,
  input  logic                 push,
  input  logic [BITNUMBER-1:0] data_in,
  input  logic                 pop,
  output logic [BITNUMBER-1:0] data_out,
  output logic                 valid_out,
  output logic                 Main_pause,
  output logic                 full,
  output logic                 empty,
  output logic                 error_out,
  output logic [2:0]           state
);

  localparam int unsigned DEPTH = 2 ** ADDR;
  localparam int unsigned CW    = ADDR + 1;

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_INIT   = 3'd1,
    S_IDLE   = 3'd2,
    S_ACTIVE = 3'd3,
    S_ERROR  = 3'd4
  } state_t;

  state_t               st, st_next;
  logic [BITNUMBER-1:0] mem [DEPTH];
  logic [ADDR-1:0]      rd_ptr, wr_ptr;
  logic [CW-1:0]        count, count_next;
  logic [LENGTH-1:0]    umbral_r;
  logic                 pop_ok, push_ok, overflow, is_full;
  logic [CW-1:0]        umb_clip, pause_thr;
  logic                 pause_next;

  assign state = st;

  // Accept decisions, next count, next state and next pause level.
  always_comb begin
    pop_ok     = pop && (count != '0);
    is_full    = (count == CW'(DEPTH));
    push_ok    = push && (st != S_ERROR) && (!is_full || pop_ok);
    overflow   = push && is_full && !pop_ok && (st != S_ERROR);
    count_next = count;
    st_next    = st;
    umb_clip   = '0;
    pause_thr  = '0;
    pause_next = 1'b0;

    case ({push_ok, pop_ok})
      2'b10:   count_next = count + CW'(1);
      2'b01:   count_next = count - CW'(1);
      default: count_next = count;
    endcase

    case (st)
      S_RESET:  st_next = init ? S_INIT : S_IDLE;
      S_INIT: begin
        if (overflow)   st_next = S_ERROR;
        else if (!init) st_next = (count_next != '0) ? S_ACTIVE : S_IDLE;
      end
      S_IDLE, S_ACTIVE: begin
        if (overflow)  st_next = S_ERROR;
        else if (init) st_next = S_INIT;
        else           st_next = (count_next != '0) ? S_ACTIVE : S_IDLE;
      end
      S_ERROR:  if (init) st_next = S_INIT;
      default:  st_next = S_RESET;
    endcase

    // Threshold is in free entries; anything at or above DEPTH pauses permanently.
    if (umbral_r >= LENGTH'(DEPTH)) umb_clip = CW'(DEPTH);
    else                            umb_clip = CW'(umbral_r);
    pause_thr  = CW'(DEPTH) - umb_clip;
    pause_next = (count_next >= pause_thr) || (st_next == S_ERROR);
  end

  // Control and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st         <= S_RESET;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      umbral_r   <= '0;
      data_out   <= '0;
      valid_out  <= 1'b0;
      Main_pause <= 1'b0;
      full       <= 1'b0;
      empty      <= 1'b1;
      error_out  <= 1'b0;
    end else begin
      st         <= st_next;
      count      <= count_next;
      valid_out  <= pop_ok;
      Main_pause <= pause_next;
      full       <= (count_next == CW'(DEPTH));
      empty      <= (count_next == '0);
      error_out  <= (st_next == S_ERROR);
      if (init && st_next == S_INIT) umbral_r <= Umbral_MF;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= rd_ptr + ADDR'(1);
      end
      if (push_ok) wr_ptr <= wr_ptr + ADDR'(1);
    end
  end

  // Storage needs no reset; reads see the pre-edge contents.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= data_in;
  end

endmodule

// File: tb/tb_main_fifo_ctrl.sv
// Directed bench for main_fifo_ctrl; a queue model feeds expected pop data to a monitor.
module tb_main_fifo_ctrl;

  logic       clk = 1'b0;
  logic       reset, init, push, pop;
  logic [7:0] Umbral_MF, data_in, data_out;
  logic       valid_out, Main_pause, full, empty, error_out;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  logic [7:0] model[$];
  logic [7:0] exp_q[$];
  logic       model_err = 1'b0;

  main_fifo_ctrl dut (
    .clk(clk), .reset(reset), .init(init), .Umbral_MF(Umbral_MF),
    .push(push), .data_in(data_in), .pop(pop), .data_out(data_out),
    .valid_out(valid_out), .Main_pause(Main_pause), .full(full),
    .empty(empty), .error_out(error_out), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Monitor: every valid word must match the oldest expected word.
  always @(negedge clk) begin
    if (reset === 1'b1 && valid_out === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_valid: got %0h want none", data_out);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        if (data_out !== e) begin
          bad++;
          $display("FAIL pop_data: got %0h want %0h", data_out, e);
        end
      end
    end
  end

  // One clock of stimulus; the model predicts acceptance independently of the DUT.
  task automatic cyc(input logic p, input logic [7:0] d, input logic q,
                     input logic i, input logic [7:0] u);
    logic pop_ok, push_ok;
    push = p; data_in = d; pop = q; init = i; Umbral_MF = u;
    pop_ok  = q && (model.size() > 0);
    push_ok = p && !model_err && ((model.size() < 8) || pop_ok);
    if (p && !model_err && model.size() == 8 && !pop_ok) model_err = 1'b1;
    else if (i && model_err) model_err = 1'b0;
    if (pop_ok)  exp_q.push_back(model.pop_front());
    if (push_ok) model.push_back(d);
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b0; init = 1'b0; push = 1'b1; pop = 1'b0; Umbral_MF = 8'd0; data_in = 8'h11;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_empty", empty, 1); chk("rst_full", full, 0);
    chk("rst_pause", Main_pause, 0); chk("rst_err", error_out, 0);
    chk("rst_valid", valid_out, 0); chk("rst_dout", data_out, 0);
    chk("rst_state", state, 0);
    push = 1'b0;
    reset = 1'b1;
    cyc(0, 8'h00, 0, 0, 8'd0);
    chk("release_idle", state, 2);

    cyc(1, 8'h24, 0, 1, 8'd1);
    chk("init_state", state, 1); chk("init_nonempty", empty, 0);
    cyc(0, 8'h00, 0, 0, 8'd1);
    chk("active_state", state, 3); chk("pause_low_c1", Main_pause, 0);

    // Threshold 1: pause from count 7, full at 8.
    for (int k = 1; k <= 7; k++) begin
      cyc(1, 8'h30 + 8'(k), 0, 0, 8'd1);
      chk("fill_pause", Main_pause, ((k + 1) >= 7) ? 1 : 0);
      chk("fill_full", full, ((k + 1) == 8) ? 1 : 0);
    end
    cyc(1, 8'hEE, 0, 0, 8'd1);
    chk("ovf_err", error_out, 1); chk("ovf_state", state, 4);
    chk("ovf_full", full, 1); chk("ovf_pause", Main_pause, 1);

    for (int k = 0; k < 8; k++) begin
      cyc(0, 8'h00, 1, 0, 8'd1);
      chk("drain_valid", valid_out, 1);
    end
    chk("drain_empty", empty, 1); chk("err_pause_forced", Main_pause, 1);
    chk("err_sticky", error_out, 1);
    cyc(0, 8'h00, 1, 0, 8'd1);
    chk("extra_pop_valid", valid_out, 0); chk("extra_pop_hold", data_out, 8'h37);
    cyc(0, 8'h00, 0, 1, 8'd0);
    chk("clr_err", error_out, 0); chk("clr_state", state, 1);
    chk("clr_pause", Main_pause, 0);
    cyc(0, 8'h00, 0, 0, 8'd0);
    chk("idle_after_init", state, 2);

    // Threshold 0: pause only when full; push+pop on full keeps count.
    for (int k = 0; k < 8; k++) begin
      cyc(1, 8'h50 + 8'(k), 0, 0, 8'd0);
      if (k == 6) chk("u0_pause_at7", Main_pause, 0);
    end
    chk("u0_pause_full", Main_pause, 1); chk("u0_full", full, 1);
    cyc(1, 8'hAA, 1, 0, 8'd0);
    chk("pp_full_full", full, 1); chk("pp_full_err", error_out, 0);
    chk("pp_full_valid", valid_out, 1); chk("pp_full_state", state, 3);
    for (int k = 0; k < 8; k++) cyc(0, 8'h00, 1, 0, 8'd0);
    chk("u0_drained", empty, 1); chk("u0_idle", state, 2);
    cyc(1, 8'hBB, 1, 0, 8'd0);
    chk("pp_empty_valid", valid_out, 0); chk("pp_empty_nonempty", empty, 0);
    chk("pp_empty_state", state, 3);
    cyc(0, 8'h00, 1, 0, 8'd0);
    chk("pp_empty_pop", valid_out, 1);
    cyc(0, 8'h00, 0, 0, 8'd0);

    // Threshold 6, five words, then asynchronous reset mid-cycle.
    cyc(0, 8'h00, 0, 1, 8'd6);
    cyc(0, 8'h00, 0, 0, 8'd6);
    for (int k = 0; k < 5; k++) cyc(1, 8'h60 + 8'(k), 0, 0, 8'd6);
    chk("u6_pause", Main_pause, 1);
    #2;
    reset = 1'b0;
    model.delete(); exp_q.delete(); model_err = 1'b0;
    #1;
    chk("async_empty", empty, 1); chk("async_pause", Main_pause, 0);
    chk("async_state", state, 0); chk("async_dout", data_out, 0);
    chk("async_full", full, 0); chk("async_valid", valid_out, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    cyc(0, 8'h00, 0, 0, 8'd0);
    chk("post_rst_idle", state, 2); chk("post_rst_empty", empty, 1);
    cyc(1, 8'h71, 0, 0, 8'd0);
    cyc(1, 8'h72, 0, 0, 8'd0);
    chk("post_rst_umbral0", Main_pause, 0);
    cyc(0, 8'h00, 1, 0, 8'd0);
    cyc(0, 8'h00, 1, 0, 8'd0);
    cyc(0, 8'h00, 0, 0, 8'd0);
    #5;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
